// File: rtl/key_char_queue_pkg.sv
// Shared keyboard definitions: PS/2 set-2 scan codes, ASCII codes and the press-to-character map.
package key_char_queue_pkg;

    localparam logic [7:0] SC_A = 8'h1C, SC_B = 8'h32, SC_C = 8'h21, SC_D = 8'h23;
    localparam logic [7:0] SC_E = 8'h24, SC_F = 8'h2B, SC_G = 8'h34, SC_H = 8'h33;
    localparam logic [7:0] SC_I = 8'h43, SC_J = 8'h3B, SC_K = 8'h42, SC_L = 8'h4B;
    localparam logic [7:0] SC_M = 8'h3A, SC_N = 8'h31, SC_O = 8'h44, SC_P = 8'h4D;
    localparam logic [7:0] SC_Q = 8'h15, SC_R = 8'h2D, SC_S = 8'h1B, SC_T = 8'h2C;
    localparam logic [7:0] SC_U = 8'h3C, SC_V = 8'h2A, SC_W = 8'h1D, SC_X = 8'h22;
    localparam logic [7:0] SC_Y = 8'h35, SC_Z = 8'h1A;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    localparam logic [7:0] ASCII_SPACE   = 8'h20;
    localparam logic [7:0] ASCII_BS      = 8'h08;
    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_CASE_MASK = 8'hDF;

    typedef struct packed {
        logic       valid;
        logic       letter;
        logic [7:0] ascii;
    } char_map_t;

    // Lowercase ASCII for mapped scan codes; valid=0 for anything else.
    function automatic char_map_t map_scan(input logic [7:0] code);
        char_map_t m;
        m        = '0;
        m.valid  = 1'b1;
        m.letter = 1'b1;
        case (code)
            SC_A: m.ascii = ASCII_LOWER_A + 8'd0;
            SC_B: m.ascii = ASCII_LOWER_A + 8'd1;
            SC_C: m.ascii = ASCII_LOWER_A + 8'd2;
            SC_D: m.ascii = ASCII_LOWER_A + 8'd3;
            SC_E: m.ascii = ASCII_LOWER_A + 8'd4;
            SC_F: m.ascii = ASCII_LOWER_A + 8'd5;
            SC_G: m.ascii = ASCII_LOWER_A + 8'd6;
            SC_H: m.ascii = ASCII_LOWER_A + 8'd7;
            SC_I: m.ascii = ASCII_LOWER_A + 8'd8;
            SC_J: m.ascii = ASCII_LOWER_A + 8'd9;
            SC_K: m.ascii = ASCII_LOWER_A + 8'd10;
            SC_L: m.ascii = ASCII_LOWER_A + 8'd11;
            SC_M: m.ascii = ASCII_LOWER_A + 8'd12;
            SC_N: m.ascii = ASCII_LOWER_A + 8'd13;
            SC_O: m.ascii = ASCII_LOWER_A + 8'd14;
            SC_P: m.ascii = ASCII_LOWER_A + 8'd15;
            SC_Q: m.ascii = ASCII_LOWER_A + 8'd16;
            SC_R: m.ascii = ASCII_LOWER_A + 8'd17;
            SC_S: m.ascii = ASCII_LOWER_A + 8'd18;
            SC_T: m.ascii = ASCII_LOWER_A + 8'd19;
            SC_U: m.ascii = ASCII_LOWER_A + 8'd20;
            SC_V: m.ascii = ASCII_LOWER_A + 8'd21;
            SC_W: m.ascii = ASCII_LOWER_A + 8'd22;
            SC_X: m.ascii = ASCII_LOWER_A + 8'd23;
            SC_Y: m.ascii = ASCII_LOWER_A + 8'd24;
            SC_Z: m.ascii = ASCII_LOWER_A + 8'd25;
            SC_SPACE: begin m.letter = 1'b0; m.ascii = ASCII_SPACE; end
            SC_BKSP:  begin m.letter = 1'b0; m.ascii = ASCII_BS;    end
            SC_ENTER: begin m.letter = 1'b0; m.ascii = ASCII_CR;    end
            default:  m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/key_char_queue_char_fifo.sv
// DEPTH x 8 character FIFO; pointers carry an extra MSB so full and empty are distinguishable.
module char_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted only when a pop frees the head slot in the same edge.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/key_char_queue.sv
// Turns keyboard press events into ASCII characters (shift/caps aware) and queues them for a consumer.
module key_char_queue
    import key_char_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_valid,
    input  logic [7:0]              last_change,
    input  logic [127:0]            key_down,
    output logic [7:0]              char_out,
    output logic                    char_valid,
    input  logic                    char_ready,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    caps_on,
    output logic                    dropped
);

    logic      press_c;
    logic      shift_c;
    logic      push_c;
    logic      pop_c;
    logic      full;
    logic      empty;
    logic [7:0] push_char_c;
    char_map_t map_c;

    // Classify the event and form the character to enqueue.
    always_comb begin
        press_c     = key_valid && !last_change[7] && key_down[last_change[6:0]];
        shift_c     = key_down[SC_LSHIFT[6:0]] || key_down[SC_RSHIFT[6:0]];
        map_c       = map_scan(last_change);
        push_c      = press_c && map_c.valid;
        push_char_c = map_c.ascii;
        if (map_c.letter && (shift_c ^ caps_on)) begin
            push_char_c = map_c.ascii & ASCII_CASE_MASK;
        end
    end

    assign char_valid = !empty;
    assign pop_c      = char_ready && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            caps_on <= 1'b0;
            dropped <= 1'b0;
        end else begin
            if (press_c && last_change == SC_CAPS) caps_on <= !caps_on;
            dropped <= push_c && full && !pop_c;
        end
    end

    char_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .din   (push_char_c),
        .pop   (pop_c),
        .dout  (char_out),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule

// File: doc/key_char_queue.md
KEY_CHAR_QUEUE -- requirements
Module: key_char_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, minimum 2.
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low (asserted at 0).
REQ-004 SHALL have port key_valid  input  1  one-cycle pulse from the keyboard decoder marking a key event.
REQ-005 SHALL have port last_change  input  8  scan code (set 2, low byte) of the event.
REQ-006 SHALL have port key_down  input  128  pressed-key bitmap, already updated in the key_valid cycle.
REQ-007 SHALL have port char_out  output  8  ASCII code at FIFO head.
REQ-008 SHALL have port char_valid  output  1  FIFO non-empty.
REQ-009 SHALL have port char_ready  input  1  consumer accepts head when high with char_valid.
REQ-010 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-011 SHALL have port caps_on  output  1  caps-lock toggle state.
REQ-012 SHALL have port dropped  output  1  one-cycle pulse when a character is discarded for lack of space.

Function
REQ-013 SHALL treat an event as a press when key_valid=1 and key_down[last_change]=1; releases SHALL be ignored except through key_down.
REQ-014 SHALL map presses: letters (1C=a, 32=b, 21=c, 23=d, 24=e, 2B=f, 34=g, 33=h, 43=i, 3B=j, 42=k, 4B=l, 3A=m, 31=n, 44=o, 4D=p, 15=q, 2D=r, 1B=s, 2C=t, 3C=u, 2A=v, 1D=w, 22=x, 35=y, 1A=z), 29 to 0x20, 66 to 0x08, 5A to 0x0D.
REQ-015 SHALL output an uppercase letter (0x41-0x5A) when shift XOR caps_on, with shift = key_down[8'h12] OR key_down[8'h59], else lowercase (0x61-0x7A); non-letters SHALL be unaffected by case.
REQ-016 SHALL toggle caps_on on each press of 8'h58 and SHALL NOT enqueue anything for shift or caps keys.
REQ-017 SHALL ignore unmapped scan codes: no push, no dropped pulse.
REQ-018 SHALL push a mapped press at the clock edge ending the key_valid cycle; char_valid SHALL rise the next cycle (latency 1).
REQ-019 SHALL pop on a clock edge where char_valid=1 and char_ready=1; char_out SHALL then present the next entry, in order.
REQ-020 SHALL, when full and a push coincides with a pop, perform both; count SHALL remain DEPTH.
REQ-021 SHALL, when full and a push occurs without a pop, discard the new character, keep contents, and pulse dropped for one cycle.
REQ-022 SHALL, when empty, ignore char_ready; char_out value is don't-care while char_valid=0.
REQ-023 SHALL wrap read/write pointers modulo DEPTH, using an extra MSB to distinguish full from empty.
REQ-024 SHALL keep count equal to pushes minus pops, within 0..DEPTH.

Reset
REQ-025 SHALL, on rst=0, asynchronously clear pointers, count=0, char_valid=0, caps_on=0, dropped=0; memory contents need not be cleared.
REQ-026 SHALL discard any in-flight key_valid coinciding with reset assertion; first push possible on the first edge after rst returns to 1.

Structure
REQ-027 SHALL place scan-code constants (letters, space, backspace, enter, shifts, caps) and ASCII constants in the shared keyboard package for reuse by the game logic.
REQ-028 SHALL implement storage as sub-module char_fifo (DEPTH x 8, push/pop/full/empty/count); mapping and caps logic SHALL stay in key_char_queue.

Verification
REQ-029 SHALL cover: press 1C with no shift, caps_on=0 -> char_out=0x61, char_valid high one cycle after key_valid.
REQ-030 SHALL cover: key_down[12]=1 then press 1C -> 0x41; press 58 then 1C with shift held -> 0x61 and caps_on=1.
REQ-031 SHALL cover: release event (key_down[1C]=0) and unmapped code 0x76 -> no push, count unchanged, dropped=0.
REQ-032 SHALL cover: 9 presses with char_ready=0, DEPTH=8 -> count=8, dropped pulses once, pop order is the first 8 characters.
REQ-033 SHALL cover: full FIFO, push with char_ready=1 same cycle -> count stays 8, new character appears last.
REQ-034 SHALL cover: rst=0 asserted mid-stream with count=5 -> count=0, char_valid=0, caps_on=0 immediately, without waiting for a clock edge.
